// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC controller: defaults, FSM
// state encodings and saturation limits.
package conv_pkg;

  localparam int FRAC_BITS_DEF   = 8;
  localparam int KERNEL_SIZE_DEF = 9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/mult_fixpoint.sv
// Sign-magnitude two's-complement multiplier; the most negative operand
// has no representable magnitude and therefore contributes zero.
module mult_fixpoint #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);

  logic [DATA_WIDTH-2:0]   ma;
  logic [DATA_WIDTH-2:0]   mb;
  logic [2*DATA_WIDTH-1:0] mag;
  logic                    neg;

  always_comb begin
    ma  = a[DATA_WIDTH-1] ? -a[DATA_WIDTH-2:0] : a[DATA_WIDTH-2:0];
    mb  = b[DATA_WIDTH-1] ? -b[DATA_WIDTH-2:0] : b[DATA_WIDTH-2:0];
    mag = (2*DATA_WIDTH)'(ma) * (2*DATA_WIDTH)'(mb);
    // a zero magnitude always yields +0 regardless of operand signs
    neg = (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]) && (mag != '0);
    p   = neg ? -mag : mag;
  end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Streaming dot-product engine: accumulates KERNEL_SIZE pixel*weight pairs,
// adds bias, rounds, saturates and presents one result per kernel.
module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pixel,
  input  logic [DATA_WIDTH-1:0] weight,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(KERNEL_SIZE) + 1) begin : g_acc_width_chk
    $error("conv_mac_ctrl: ACC_WIDTH too small for DATA_WIDTH/KERNEL_SIZE");
  end

  localparam int CW = $clog2(KERNEL_SIZE + 1);
  localparam logic [CW-1:0] KLAST_M1 = CW'(KERNEL_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] RND =
    (FRAC_BITS > 0) ? (ACC_WIDTH'(1) << (FRAC_BITS - 1)) : '0;

  logic [1:0]                    state;
  logic [CW-1:0]                 count;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [2*DATA_WIDTH-1:0]       prod;
  logic [2*DATA_WIDTH-1:0]       prod_q;
  logic                          p_valid;
  logic [DATA_WIDTH-1:0]         bias_q;
  logic                          accept;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]         result;

  mult_fixpoint #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .a (pixel),
    .b (weight),
    .p (prod)
  );

  always_comb begin
    in_ready = !rst && ((state == ST_IDLE) || (state == ST_ACCUM));
    accept   = in_valid && in_ready;
    busy     = (state != ST_IDLE);
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod_q[2*DATA_WIDTH-1]}}, prod_q};
    sum      = acc
             + ({{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q} <<< FRAC_BITS)
             + RND;
    shifted  = sum >>> FRAC_BITS;
    if (shifted > SAT_HI)      result = SAT_HI[DATA_WIDTH-1:0];
    else if (shifted < SAT_LO) result = SAT_LO[DATA_WIDTH-1:0];
    else                       result = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      acc       <= '0;
      prod_q    <= '0;
      p_valid   <= 1'b0;
      bias_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) prod_q <= prod;
      case (state)
        ST_IDLE: if (accept) begin
          count  <= CW'(1);
          bias_q <= bias;
          acc    <= '0;
          state  <= (KERNEL_SIZE == 1) ? ST_DRAIN : ST_ACCUM;
        end
        ST_ACCUM: begin
          if (p_valid) acc <= acc + prod_ext;
          if (accept) begin
            count <= count + CW'(1);
            if (count == KLAST_M1) state <= ST_DRAIN;
          end
        end
        // the product of the final pair lands one edge after its accept,
        // so the result is formed only once no product is pending
        ST_DRAIN: begin
          if (p_valid) begin
            acc <= acc + prod_ext;
          end else begin
            out_data  <= result;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          count     <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_mac_ctrl.md
CONV_MAC_CTRL -- requirements
Module: conv_mac_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width in two's-complement fixed point.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of operands, bias and result.
REQ-003 SHALL have parameter KERNEL_SIZE, default 9, number of pixel/weight pairs per dot product.
REQ-004 SHALL have parameter ACC_WIDTH, default 40, accumulator width.
REQ-005 SHALL have one clock; reset is synchronous and active-high: ports clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-006 SHALL have the following data and handshake ports:
  in_valid  input  1  pair valid
  in_ready  output 1  pair accepted when in_valid&in_ready
  pixel     input  DATA_WIDTH  activation operand
  weight    input  DATA_WIDTH  kernel operand
  bias      input  DATA_WIDTH  sampled with first pair of a kernel
  out_valid output 1  result valid
  out_ready input  1  result consumed when out_valid&out_ready
  out_data  output DATA_WIDTH  rounded, saturated result
  busy      output 1  state != IDLE

Function
REQ-007 SHALL implement states IDLE, ACCUM, DRAIN, OUTPUT.
REQ-008 IDLE: in_ready=1; first accepted pair -> ACCUM, count=1, bias latched, accumulator cleared.
REQ-009 ACCUM: in_ready=1 while count<KERNEL_SIZE; accepted pair increments count; K-th accepted pair -> DRAIN.
REQ-010 in_valid low in ACCUM SHALL stall without losing count or accumulator (no timeout).
REQ-011 Each accepted pair SHALL drive the multiplier combinationally; the 2*DATA_WIDTH product is registered at the accept edge (p_valid set).
REQ-012 A registered product SHALL be sign-extended to ACC_WIDTH and added to the accumulator on the next edge.
REQ-013 Multiplier rule: magnitudes use bits [DATA_WIDTH-2:0] after negation, so operand 0x8000 contributes magnitude 0; a zero product is +0.
REQ-014 DRAIN: in_ready=0; after the last product is accumulated, out_data SHALL be registered as sat((acc + (bias<<<FRAC_BITS) + 2^(FRAC_BITS-1)) >>> FRAC_BITS), then -> OUTPUT.
REQ-015 Saturation SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-016 Latency: out_valid SHALL rise 2 edges after the edge accepting the K-th pair.
REQ-017 OUTPUT: out_valid=1, in_ready=0, out_data stable until out_ready; handshake edge -> IDLE, out_valid=0.
REQ-018 Pairs SHALL NOT be accepted in DRAIN or OUTPUT; the next kernel starts no earlier than the cycle after the output handshake.
REQ-019 Accumulator overflow within ACC_WIDTH is not checked; ACC_WIDTH SHALL be >= 2*DATA_WIDTH+clog2(KERNEL_SIZE)+1 (elaboration check).

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, count=0, acc=0, p_valid=0, out_valid=0, out_data=0, busy=0, from any state including mid-ACCUM.
REQ-021 in_ready SHALL be 0 while rst is high and 1 in the first cycle after reset releases.

Structure
REQ-022 State encoding, FRAC_BITS/KERNEL_SIZE defaults and the saturation limits SHALL live in shared package conv_pkg.
REQ-023 SHALL instantiate exactly one mult_fixpoint (DATA_WIDTH passed through); no other multiplier.

Verification (FRAC_BITS=8, KERNEL_SIZE=9)
REQ-024 9 pairs pixel=0x0100, weight=0x0100, bias=0 -> out_data=0x0900, out_valid 2 edges after 9th accept.
REQ-025 9 pairs pixel=0xFF00, weight=0x0100, bias=0x0080 -> out_data=0xF780 (-8.5).
REQ-026 9 pairs 0x7FFF x 0x7FFF -> out_data=0x7FFF; 0x8001 x 0x7FFF -> 0x8000; any pair with 0x8000 -> contributes 0.
REQ-027 out_ready low 5 cycles in OUTPUT -> out_data/out_valid held, in_ready=0; handshake -> IDLE next cycle.
REQ-028 rst after 4 pairs, then 9 pairs of 0x0100 x 0x0200 -> out_data=0x1200, no residue from aborted kernel.
REQ-029 in_valid toggled randomly during ACCUM -> exactly 9 accepts, same result as REQ-024 stimulus.
